// File: rtl/fifo_ram_ctrl.sv
// FWFT FIFO controller driving an external simple dual-port RAM.
// The RAM has an unregistered output. A 2-entry output buffer (head/spare) hides
// the one-cycle RAM read latency, so one push and one pop can complete every cycle.
module fifo_ram_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AFULL_TH   = 14,
   parameter int unsigned AEMPTY_TH  = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    wr_en_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   input  logic                    rd_en_i,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic [ADDR_WIDTH+1:0]   data_cnt_o,
   output logic                    overflow_o,
   output logic                    underflow_o,
   output logic                    ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_wr_addr_o,
   output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
   output logic                    ram_rd_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]   ram_rd_data_i
);

   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
   localparam int unsigned DCNT_W = ADDR_WIDTH + 2;

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      ram_cnt;
   logic                  inflight;
   logic                  head_valid;
   logic                  spare_valid;
   logic [DATA_WIDTH-1:0] spare;

   logic                  push_c;
   logic                  pop_c;
   logic                  issue_c;
   logic [1:0]            occ_c;
   logic [CNT_W-1:0]      ram_cnt_nxt;
   logic [DCNT_W-1:0]     dcnt_nxt;
   logic [DATA_WIDTH-1:0] head_nxt;
   logic [DATA_WIDTH-1:0] spare_nxt;
   logic                  hv_nxt;
   logic                  sv_nxt;

   // Accepted push/pop and RAM read issue; push is blocked while reset is held.
   assign push_c  = wr_en_i & ~full_o & rst_n_i;
   assign pop_c   = rd_en_i & head_valid;
   assign occ_c   = 2'(head_valid) + 2'(spare_valid) + 2'(inflight) - 2'(pop_c);
   assign issue_c = (ram_cnt != '0) && (occ_c < 2'd2);

   // RAM ports are driven straight from the current-cycle decisions.
   assign ram_wr_en_o   = push_c;
   assign ram_wr_addr_o = wr_ptr;
   assign ram_wr_data_o = wr_data_i;
   assign ram_rd_en_o   = issue_c;
   assign ram_rd_addr_o = rd_ptr;
   assign empty_o       = ~head_valid;

   // Next state of the output buffer: pop shifts spare to head, landing data fills the first free slot.
   always_comb begin
      head_nxt  = rd_data_o;
      hv_nxt    = head_valid;
      spare_nxt = spare;
      sv_nxt    = spare_valid;
      if (pop_c) begin
         if (spare_valid) head_nxt = spare;
         hv_nxt = spare_valid;
         sv_nxt = 1'b0;
      end
      if (inflight) begin
         if (!hv_nxt) begin
            head_nxt = ram_rd_data_i;
            hv_nxt   = 1'b1;
         end else begin
            spare_nxt = ram_rd_data_i;
            sv_nxt    = 1'b1;
         end
      end
      ram_cnt_nxt = ram_cnt + CNT_W'(push_c) - CNT_W'(issue_c);
      dcnt_nxt    = DCNT_W'(ram_cnt_nxt) + DCNT_W'(issue_c) + DCNT_W'(hv_nxt) + DCNT_W'(sv_nxt);
   end

   // State and registered status flags; reset drops all content including in-flight data.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         ram_cnt        <= '0;
         inflight       <= 1'b0;
         head_valid     <= 1'b0;
         spare_valid    <= 1'b0;
         spare          <= '0;
         rd_data_o      <= '0;
         full_o         <= 1'b0;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         data_cnt_o     <= '0;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         if (push_c)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (issue_c) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         ram_cnt        <= ram_cnt_nxt;
         inflight       <= issue_c;
         head_valid     <= hv_nxt;
         spare_valid    <= sv_nxt;
         spare          <= spare_nxt;
         rd_data_o      <= head_nxt;
         full_o         <= (ram_cnt_nxt == CNT_W'(DEPTH));
         almost_full_o  <= (ram_cnt_nxt >= CNT_W'(AFULL_TH));
         almost_empty_o <= (dcnt_nxt <= DCNT_W'(AEMPTY_TH));
         data_cnt_o     <= dcnt_nxt;
         overflow_o     <= wr_en_i & full_o;
         underflow_o    <= rd_en_i & ~head_valid;
      end
   end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: behavioural RAM plus a count/queue-level reference model.
module tb_fifo_ram_ctrl;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 4;
   localparam int          DEPTH = 16;
   localparam int          AF_TH = 14;
   localparam int          AE_TH = 2;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          wr_en_i;
   logic [DW-1:0] wr_data_i;
   logic          rd_en_i;
   logic [DW-1:0] rd_data_o;
   logic          empty_o, full_o, almost_full_o, almost_empty_o;
   logic [AW+1:0] data_cnt_o;
   logic          overflow_o, underflow_o;
   logic          ram_wr_en_o;
   logic [AW-1:0] ram_wr_addr_o;
   logic [DW-1:0] ram_wr_data_o;
   logic          ram_rd_en_o;
   logic [AW-1:0] ram_rd_addr_o;
   logic [DW-1:0] ram_rd_data_i;

   fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
      .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o),
      .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
      .data_cnt_o(data_cnt_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
      .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
      .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i)
   );

   always #5 clk_i = ~clk_i;

   // Simple dual-port RAM: read data valid for exactly one cycle, garbage otherwise.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk_i) begin
      if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
      if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
      else             ram_rd_data_i <= DW'($urandom);
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queue of held words, plus where they sit (RAM / in flight / buffer).
   logic [DW-1:0] q[$];
   int n_ram, n_fly, n_buf, wr_cnt, rd_cnt;
   logic [DW-1:0] last_head;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      n_ram = 0; n_fly = 0; n_buf = 0; wr_cnt = 0; rd_cnt = 0;
      last_head = '0;
   endtask

   task automatic check_state(input bit exp_ovf, input bit exp_unf);
      check("empty",        empty_o,        n_buf == 0);
      check("full",         full_o,         n_ram == DEPTH);
      check("data_cnt",     data_cnt_o,     q.size());
      check("almost_full",  almost_full_o,  n_ram >= AF_TH);
      check("almost_empty", almost_empty_o, q.size() <= AE_TH);
      check("overflow",     overflow_o,     exp_ovf);
      check("underflow",    underflow_o,    exp_unf);
      check("rd_data",      rd_data_o,      last_head);
   endtask

   // One clock cycle: drive at negedge, check RAM port decisions, then check state after the edge.
   task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd);
      bit push_m, pop_m, iss_m;
      @(negedge clk_i);
      wr_en_i = wr; wr_data_i = d; rd_en_i = rd;
      #1;
      push_m = wr && (n_ram != DEPTH);
      pop_m  = rd && (n_buf > 0);
      iss_m  = (n_ram > 0) && (n_buf + n_fly - int'(pop_m) < 2);
      check("ram_wr_en", ram_wr_en_o, push_m);
      if (push_m) begin
         check("ram_wr_addr", ram_wr_addr_o, wr_cnt % DEPTH);
         check("ram_wr_data", ram_wr_data_o, d);
      end
      check("ram_rd_en", ram_rd_en_o, iss_m);
      if (iss_m) check("ram_rd_addr", ram_rd_addr_o, rd_cnt % DEPTH);
      if (pop_m) check("pop_data", rd_data_o, q[0]);
      @(posedge clk_i);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin q.push_back(d); wr_cnt++; end
      if (iss_m) rd_cnt++;
      n_buf = n_buf - int'(pop_m) + n_fly;
      n_fly = int'(iss_m);
      n_ram = n_ram + int'(push_m) - int'(iss_m);
      if (n_buf > 0) last_head = q[0];
      #1;
      check_state(wr && !push_m, rd && !pop_m);
   endtask

   initial begin
      int pw, pr;
      rst_n_i = 1'b0; wr_en_i = 1'b0; wr_data_i = '0; rd_en_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_state(1'b0, 1'b0);
      check("rst_ram_wr_en", ram_wr_en_o, 1'b0);
      check("rst_ram_rd_en", ram_rd_en_o, 1'b0);
      #1 rst_n_i = 1'b1;

      // Single push latency
      step(1'b1, 16'h1234, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
      check("single_word", rd_data_o, 16'h1234);

      // Drain it, then fill to overflow with no pops
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 19; i++) step(1'b1, DW'(i), 1'b0);
      check("full_cnt", data_cnt_o, 18);
      step(1'b1, 16'hAAAA, 1'b0);
      check("full_cnt_hold", data_cnt_o, 18);

      // Pop everything, including underflow attempts at the end
      for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Sustained push+pop streaming across pointer wraps
      for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h100 + i), 1'b0);
      repeat (4) step(1'b0, '0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, DW'(16'h200 + i), 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

      // Reset with words held and one read in flight
      for (int i = 0; i < 6; i++) step(1'b1, DW'(16'h300 + i), 1'b0);
      step(1'b0, '0, 1'b1);
      #1;
      rst_n_i = 1'b0; wr_en_i = 1'b1; rd_en_i = 1'b1;
      model_reset();
      #1;
      check_state(1'b0, 1'b0);
      check("rst_mid_ram_wr_en", ram_wr_en_o, 1'b0);
      check("rst_mid_ram_rd_en", ram_rd_en_o, 1'b0);
      repeat (3) @(posedge clk_i);
      wr_en_i = 1'b0; rd_en_i = 1'b0;
      #2 rst_n_i = 1'b1;
      step(1'b1, 16'hBEEF, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
      check("beef_first", rd_data_o, 16'hBEEF);
      step(1'b0, '0, 1'b1);

      // Randomised traffic in phases with varying push/pop bias
      pw = 50; pr = 50;
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) begin
            pw = 10 + 40 * int'($urandom_range(0, 2));
            pr = 10 + 40 * int'($urandom_range(0, 2));
         end
         step(int'($urandom_range(0, 99)) < pw, DW'($urandom), int'($urandom_range(0, 99)) < pr);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
